fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Shares the write port of the 8-entry synchronous FIFO between NREQ producers.
//  Round-robin arbitration with bounded bursts; valid/ready handshake per producer.
//  Registers the winner's data onto fifo_wr/fifo_din and keeps a slot-reservation
//  counter, so the FIFO is never written while full.
//  Sits between the producer agents and the FIFO write side.
// PARAMETERS
//  NREQ       4  number of requesters (2..8)
//  DW         8  data width, equals FIFO din width
//  DEPTH      8  FIFO depth in entries
//  MAX_BURST  4  max consecutive grants to one requester while others wait (>=1)
// PORTS
//  clk          in   1                 clock, all state on posedge
//  reset        in   1                 asynchronous, active-high
//  req_valid    in   NREQ              requester i has a word
//  req_data     in   NREQ*DW           word of requester i at [i*DW +: DW]
//  req_ready    out  NREQ              one-hot accept, combinational
//  fifo_wr      out  1                 registered write strobe to FIFO
//  fifo_din     out  DW                registered write data to FIFO
//  fifo_pop     in   1                 effective FIFO read this cycle (rd & !empty)
//  occupancy    out  clog2(DEPTH+1)    reserved slots, incl. write in flight
//  grant_id     out  clog2(NREQ)       index of current/last grant
//  hold_active  out  1                 1 while in HOLD state
// BEHAVIOUR
//  Reset: fifo_wr=0, fifo_din=0, occupancy=0, grant_id=NREQ-1, state IDLE,
//   burst_cnt=0, and req_ready=0 while reset is high. Requester 0 has first priority.
//  Transfer i: req_valid[i] & req_ready[i]. At most one req_ready bit is high.
//   req_ready is never high when occupancy==DEPTH.
//  Latency: 1 cycle. A transfer in cycle N gives fifo_wr=1 and fifo_din=that data
//   in cycle N+1. fifo_wr=0 in every other cycle. fifo_din holds its last value.
//  occupancy: +1 on transfer, -1 on fifo_pop, unchanged when both happen.
//   Saturates: no decrement at 0. No pop credit is taken in the same cycle, so a
//   FIFO at DEPTH with a pop that cycle still grants nothing.
//  FSM IDLE: candidate = first requester with req_valid, searching upward (with wrap)
//   from grant_id+1. If a candidate exists and occupancy<DEPTH: ready to it,
//   grant_id<=cand, burst_cnt<=1, go to HOLD.
//  FSM HOLD(g): if req_valid[g] & occupancy<DEPTH & (burst_cnt<MAX_BURST or no other
//   valid): ready to g, burst_cnt+1 (saturating at MAX_BURST).
//   If burst_cnt==MAX_BURST and another requester is valid: no grant this cycle,
//   go to IDLE. The search then starts at g+1.
//   If req_valid[g]==0: go to IDLE in the same cycle with no grant. Re-arbitrate next cycle.
//   If occupancy==DEPTH: stay in HOLD, burst_cnt frozen, no ready.
//  Bubble rule: every HOLD->IDLE exit costs exactly 1 idle cycle.
//  req_valid may drop without transfer. Data is sampled only on a transfer cycle.
//  Reset mid-operation clears all state immediately. A write already registered
//   is discarded (fifo_wr forced 0). The FIFO is reset by the same reset.
// TESTING
//  1 Single: reset, req_valid=0001, data0=0xA5 -> req_ready=0001 in the same cycle;
//    fifo_wr=1 and fifo_din=0xA5 next cycle; occupancy=1.
//  2 Round-robin: all 4 valid, MAX_BURST=4, no pops -> grants 0,0,0,0,(bubble),1,1,1,1;
//    occupancy reaches 8, then req_ready=0 and fifo_wr=0 thereafter.
//  3 Full/pop: fill to 8, hold req1 valid, pulse fifo_pop once -> occupancy 7, then
//    one grant to req1 the following cycle, back to 8. Never 9.
//  4 Simultaneous: occupancy=5, transfer and fifo_pop in the same cycle ->
//    occupancy stays 5. Pop at occupancy 0 -> stays 0.
//  5 Drop: req2 held, req_valid[2] falls after 2 grants -> IDLE, next grant goes to
//    req3 (valid), grant_id=3.
//  6 Reset: assert reset in the cycle after a transfer -> fifo_wr=0 and occupancy=0
//    at once. After release, requester 0 wins first.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for a shared synchronous FIFO: bounded bursts,
// one-hot combinational ready, registered write strobe/data, slot reservation count.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int DEPTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ*DW-1:0]           req_data,
  output logic [NREQ-1:0]              req_ready,
  output logic                         fifo_wr,
  output logic [DW-1:0]                fifo_din,
  input  logic                         fifo_pop,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [$clog2(NREQ)-1:0]      grant_id,
  output logic                         hold_active
);

  localparam int OW = $clog2(DEPTH+1);
  localparam int GW = $clog2(NREQ);
  localparam int BW = $clog2(MAX_BURST+1);
  localparam logic [OW-1:0] DEPTH_L = OW'(DEPTH);
  localparam logic [BW-1:0] MAXB_L  = BW'(MAX_BURST);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t          r_state;
  logic [BW-1:0]   r_burst;
  logic [OW-1:0]   r_occ;
  logic [GW-1:0]   r_gid;
  logic            r_vld_p1;
  logic [DW-1:0]   r_din_p1;

  logic [GW-1:0]   w_cand;
  logic            w_cand_ok;
  logic            w_full;
  logic            w_others;
  logic            w_grant;
  logic [GW-1:0]   w_gidx;
  state_t          w_nstate;
  logic [BW-1:0]   w_nburst;

  // Round-robin search: lowest offset from the last grant wins.
  always_comb begin
    logic [GW-1:0] idx;
    w_cand    = '0;
    w_cand_ok = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = GW'((int'(r_gid) + k) % NREQ);
      if (req_valid[idx]) begin
        w_cand    = idx;
        w_cand_ok = 1'b1;
      end
    end
  end

  assign w_full   = (r_occ == DEPTH_L);
  assign w_others = |(req_valid & ~(NREQ'(1) << r_gid));

  always_comb begin
    w_grant  = 1'b0;
    w_gidx   = r_gid;
    w_nstate = r_state;
    w_nburst = r_burst;
    case (r_state)
      S_IDLE: begin
        if (w_cand_ok && !w_full) begin
          w_grant  = 1'b1;
          w_gidx   = w_cand;
          w_nburst = BW'(1);
          w_nstate = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!req_valid[r_gid]) begin
          w_nstate = S_IDLE;
        end else if (!w_full) begin
          // Full FIFO keeps the hold with the burst count frozen.
          if (r_burst < MAXB_L || !w_others) begin
            w_grant = 1'b1;
            if (r_burst < MAXB_L) w_nburst = r_burst + BW'(1);
          end else begin
            w_nstate = S_IDLE;
          end
        end
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  assign req_ready = (w_grant && !reset) ? (NREQ'(1) << w_gidx) : '0;

  // Stage p1: registered FIFO write, reservation counter and FSM state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_burst  <= '0;
      r_occ    <= '0;
      r_gid    <= GW'(NREQ-1);
      r_vld_p1 <= 1'b0;
      r_din_p1 <= '0;
    end else begin
      r_state  <= w_nstate;
      r_burst  <= w_nburst;
      r_vld_p1 <= w_grant;
      if (w_grant) begin
        r_gid    <= w_gidx;
        r_din_p1 <= req_data[w_gidx*DW +: DW];
      end
      if (w_grant && !fifo_pop)
        r_occ <= r_occ + OW'(1);
      else if (!w_grant && fifo_pop && r_occ != '0)
        r_occ <= r_occ - OW'(1);
    end
  end

  assign fifo_wr     = r_vld_p1;
  assign fifo_din    = r_din_p1;
  assign occupancy   = r_occ;
  assign grant_id    = r_gid;
  assign hold_active = (r_state == S_HOLD);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: single transfer, round-robin bursts,
// full/pop credit, simultaneous push/pop, valid drop and mid-run reset.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_wr;
  logic [7:0]  fifo_din;
  logic        fifo_pop;
  logic [3:0]  occupancy;
  logic [1:0]  grant_id;
  logic        hold_active;

  int n_chk = 0;
  int n_bad = 0;

  fifo_wr_arbiter #(.NREQ(4), .DW(8), .DEPTH(8), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_wr(fifo_wr), .fifo_din(fifo_din),
    .fifo_pop(fifo_pop), .occupancy(occupancy), .grant_id(grant_id),
    .hold_active(hold_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    fifo_pop = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  logic [3:0] exp_rdy [12];
  logic [3:0] exp_occ [12];
  logic       exp_wr  [12];
  logic [7:0] exp_din [12];

  initial begin
    exp_rdy = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010,
                4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
    exp_occ = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd8, 4'd8, 4'd8};
    exp_wr  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_din = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h22,
                8'h22, 8'h22, 8'h22, 8'h22, 8'h22, 8'h22};

    reset = 1'b1;
    req_valid = '0;
    req_data = '0;
    fifo_pop = 1'b0;
    cyc();
    cyc();

    // Reset state, ready gated while reset is high
    req_valid = 4'b0001;
    req_data  = 32'h000000A5;
    #1;
    chk("rst_ready", req_ready, 4'b0000);
    chk("rst_wr", fifo_wr, 1'b0);
    chk("rst_din", fifo_din, 8'h00);
    chk("rst_occ", occupancy, 4'd0);
    chk("rst_gid", grant_id, 2'd3);
    chk("rst_hold", hold_active, 1'b0);

    // 1: single transfer
    cyc();
    reset = 1'b0;
    #1;
    chk("t1_ready", req_ready, 4'b0001);
    cyc();
    chk("t1_wr", fifo_wr, 1'b1);
    chk("t1_din", fifo_din, 8'hA5);
    chk("t1_occ", occupancy, 4'd1);
    chk("t1_gid", grant_id, 2'd0);
    chk("t1_hold", hold_active, 1'b1);
    req_valid = '0;
    cyc();
    chk("t1_wr_off", fifo_wr, 1'b0);
    chk("t1_din_hold", fifo_din, 8'hA5);

    // 2: round-robin with bursts until full
    do_reset();
    req_valid = 4'b1111;
    req_data  = 32'h44332211;
    for (int i = 0; i < 12; i++) begin
      #1;
      chk($sformatf("t2_ready%0d", i), req_ready, exp_rdy[i]);
      cyc();
      chk($sformatf("t2_wr%0d", i), fifo_wr, exp_wr[i]);
      chk($sformatf("t2_occ%0d", i), occupancy, exp_occ[i]);
      chk($sformatf("t2_din%0d", i), fifo_din, exp_din[i]);
    end
    chk("t2_gid", grant_id, 2'd1);
    chk("t2_hold", hold_active, 1'b1);

    // 3: full, single pop frees one slot for req1
    req_valid = 4'b0010;
    req_data[15:8] = 8'h5C;
    fifo_pop = 1'b1;
    #1;
    chk("t3_ready_full_pop", req_ready, 4'b0000);
    cyc();
    fifo_pop = 1'b0;
    chk("t3_occ7", occupancy, 4'd7);
    chk("t3_wr0", fifo_wr, 1'b0);
    #1;
    chk("t3_ready1", req_ready, 4'b0010);
    cyc();
    chk("t3_occ8", occupancy, 4'd8);
    chk("t3_wr1", fifo_wr, 1'b1);
    chk("t3_din", fifo_din, 8'h5C);
    #1;
    chk("t3_ready_full", req_ready, 4'b0000);
    cyc();
    chk("t3_occ_stay8", occupancy, 4'd8);
    chk("t3_wr_off", fifo_wr, 1'b0);

    // 4: simultaneous transfer and pop; pop at empty
    do_reset();
    req_valid = 4'b0001;
    for (int i = 0; i < 5; i++) cyc();
    chk("t4_occ5", occupancy, 4'd5);
    fifo_pop = 1'b1;
    #1;
    chk("t4_ready", req_ready, 4'b0001);
    cyc();
    chk("t4_occ_same", occupancy, 4'd5);
    chk("t4_wr", fifo_wr, 1'b1);
    req_valid = '0;
    cyc();
    chk("t4_occ_pop", occupancy, 4'd4);
    do_reset();
    fifo_pop = 1'b1;
    cyc();
    cyc();
    fifo_pop = 1'b0;
    chk("t4_occ_empty_pop", occupancy, 4'd0);

    // 5: holder drops valid, next grant goes to req3
    do_reset();
    req_valid = 4'b0100;
    req_data  = 32'h88776655;
    #1;
    chk("t5_ready2", req_ready, 4'b0100);
    cyc();
    chk("t5_gid2", grant_id, 2'd2);
    cyc();
    chk("t5_occ2", occupancy, 4'd2);
    req_valid = 4'b1000;
    #1;
    chk("t5_ready_drop", req_ready, 4'b0000);
    cyc();
    chk("t5_hold_off", hold_active, 1'b0);
    chk("t5_wr_off", fifo_wr, 1'b0);
    #1;
    chk("t5_ready3", req_ready, 4'b1000);
    cyc();
    chk("t5_gid3", grant_id, 2'd3);
    chk("t5_din", fifo_din, 8'h88);
    chk("t5_occ3", occupancy, 4'd3);

    // 6: reset right after a transfer
    do_reset();
    req_valid = 4'b1111;
    req_data  = 32'h44332211;
    cyc();
    chk("t6_wr_pre", fifo_wr, 1'b1);
    reset = 1'b1;
    #1;
    chk("t6_wr_rst", fifo_wr, 1'b0);
    chk("t6_occ_rst", occupancy, 4'd0);
    chk("t6_ready_rst", req_ready, 4'b0000);
    cyc();
    reset = 1'b0;
    #1;
    chk("t6_ready0", req_ready, 4'b0001);
    cyc();
    chk("t6_gid0", grant_id, 2'd0);
    chk("t6_din", fifo_din, 8'h11);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
